// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_pkg: shared constants for the 7-segment scan decoder and its
// pattern-decode helper.
//   ERR_*      : err_code values reported by seg_scan_decoder
//   scan_state_e : scan-tracking FSM encoding
//   SEG_BLANK  : active-low "all segments off" pattern
package seg_scan_pkg;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BAD_SEG  = 2'b01;
  localparam logic [1:0] ERR_MULTI_AN = 2'b10;
  localparam logic [1:0] ERR_ORDER    = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_scan_decoder_seg7.sv
// seg7_pattern_decode: combinational lookup of an active-low a..g segment
// pattern (a = MSB) into a hex nibble. Kept as its own module so every
// display block shares a single copy of the hex table.
//   pat_i      in  7  active-low segment pattern
//   val_o      out 4  decoded value (0 when not a hex glyph)
//   is_blank_o out 1  pattern is all segments off
//   is_bad_o   out 1  pattern is neither a hex glyph nor blank
module seg7_pattern_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] val_o,
  output logic       is_blank_o,
  output logic       is_bad_o
);

  always_comb begin
    val_o      = 4'h0;
    is_blank_o = 1'b0;
    is_bad_o   = 1'b0;
    case (pat_i)
      7'b0000001: val_o = 4'h0;
      7'b1001111: val_o = 4'h1;
      7'b0010010: val_o = 4'h2;
      7'b0000110: val_o = 4'h3;
      7'b1001100: val_o = 4'h4;
      7'b0100100: val_o = 4'h5;
      7'b0100000: val_o = 4'h6;
      7'b0001111: val_o = 4'h7;
      7'b0000000: val_o = 4'h8;
      7'b0000100: val_o = 4'h9;
      7'b0000010: val_o = 4'hA;
      7'b1100000: val_o = 4'hB;
      7'b0110001: val_o = 4'hC;
      7'b1000010: val_o = 4'hD;
      7'b0110000: val_o = 4'hE;
      7'b0111000: val_o = 4'hF;
      SEG_BLANK:  is_blank_o = 1'b1;
      default:    is_bad_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: snoops a multiplexed common-anode 7-segment scan bus and
// recovers the hex value shown on each digit, flagging scan-protocol faults.
//
// Optional feature macro: SEGDEC_DP_EN (adds dp_vals, includes dp in the
// stability compare). Without it, dp is ignored.
//
// Ports:
//   mclk       in              master clock
//   clr_n      in              async active-low reset
//   an         in  NUM_DIG     anode selects, active-low, bit 0 = rightmost
//   a_to_g     in  7           segments, active-low, a = MSB
//   dp         in  1           decimal point, active-low
//   digits     out 4*NUM_DIG   decoded values, digit i at [4i+3:4i]
//   digit_vld  out NUM_DIG     digit holds a committed non-blank value
//   frame_done out 1           pulse on wrap from digit NUM_DIG-1 to 0
//   err        out 1           one-cycle error pulse
//   err_code   out 2           cause of last err (held)
//   stale      out 1           scan has stalled
//   dp_vals    out NUM_DIG     committed decimal points, 1 = lit (SEGDEC_DP_EN)
//
// state  | meaning
// IDLE   | no single anode active; waiting for a digit
// SETTLE | digit captured, counting identical samples toward commit
// HOLD   | digit committed; waiting for the bus to move on
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIG     = 8,
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 2097152
) (
  input  logic                 mclk,
  input  logic                 clr_n,
  input  logic [NUM_DIG-1:0]   an,
  input  logic [6:0]           a_to_g,
  input  logic                 dp,
  output logic [4*NUM_DIG-1:0] digits,
  output logic [NUM_DIG-1:0]   digit_vld,
  output logic                 frame_done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic                 stale
`ifdef SEGDEC_DP_EN
  ,
  output logic [NUM_DIG-1:0]   dp_vals
`endif
);

  localparam int IDX_W  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int STAB_W = $clog2(STABLE_CYC + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [NUM_DIG-1:0] ONE_N     = {{(NUM_DIG-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_DIG - 1);
  localparam logic [STAB_W-1:0]  STAB_ONE  = {{(STAB_W-1){1'b0}}, 1'b1};
  localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(STABLE_CYC - 1);
  localparam logic [TMO_W-1:0]   TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]   TMO_MAX   = TMO_W'(TIMEOUT_CYC);

  // input sample registers
  logic [NUM_DIG-1:0] s_an_q;
  logic [6:0]         s_seg_q;

  // FSM and capture
  scan_state_e        state_q, state_d;
  logic [IDX_W-1:0]   cap_idx_q, cap_idx_d;
  logic [6:0]         cap_seg_q, cap_seg_d;
  logic [STAB_W-1:0]  stab_cnt_q, stab_cnt_d;

  // scan tracking and outputs
  logic [IDX_W-1:0]     last_idx_q, last_idx_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [4*NUM_DIG-1:0] digits_q, digits_d;
  logic [NUM_DIG-1:0]   vld_q, vld_d;
  logic                 frame_done_q, frame_done_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic                 stale_q, stale_d;

  logic [NUM_DIG-1:0] an_hot;
  logic               an_none, an_one, an_multi;
  logic [IDX_W-1:0]   an_idx;
  logic               dp_match;
  logic               samp_match;
  logic               commit;
  logic               multi_err;
  logic [IDX_W-1:0]   exp_idx;
  logic [3:0]         dec_val;
  logic               dec_blank, dec_bad;

`ifdef SEGDEC_DP_EN
  logic               s_dp_q;
  logic               cap_dp_q, cap_dp_d;
  logic [NUM_DIG-1:0] dp_vals_q, dp_vals_d;
`else
  logic               dp_unused;
  assign dp_unused = dp;
`endif

  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      s_an_q  <= '1;
      s_seg_q <= SEG_BLANK;
`ifdef SEGDEC_DP_EN
      s_dp_q  <= 1'b1;
`endif
    end else begin
      s_an_q  <= an;
      s_seg_q <= a_to_g;
`ifdef SEGDEC_DP_EN
      s_dp_q  <= dp;
`endif
    end
  end

  // Anode classification: one-hot test on the inverted (active-high) copy.
  always_comb begin
    an_hot   = ~s_an_q;
    an_none  = (an_hot == '0);
    an_one   = !an_none && ((an_hot & (an_hot - ONE_N)) == '0);
    an_multi = !an_none && !an_one;
    an_idx   = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (an_hot[i]) an_idx = IDX_W'(i);
    end
  end

`ifdef SEGDEC_DP_EN
  assign dp_match = (s_dp_q == cap_dp_q);
`else
  assign dp_match = 1'b1;
`endif

  assign samp_match = an_one && (an_idx == cap_idx_q) &&
                      (s_seg_q == cap_seg_q) && dp_match;

  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      cap_idx_q  <= '0;
      cap_seg_q  <= '0;
      stab_cnt_q <= '0;
`ifdef SEGDEC_DP_EN
      cap_dp_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cap_idx_q  <= cap_idx_d;
      cap_seg_q  <= cap_seg_d;
      stab_cnt_q <= stab_cnt_d;
`ifdef SEGDEC_DP_EN
      cap_dp_q   <= cap_dp_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_idx_d  = cap_idx_q;
    cap_seg_d  = cap_seg_q;
    stab_cnt_d = stab_cnt_q;
`ifdef SEGDEC_DP_EN
    cap_dp_d   = cap_dp_q;
`endif
    commit     = 1'b0;
    multi_err  = 1'b0;

    if ((state_q == SETTLE) && samp_match) begin
      stab_cnt_d = stab_cnt_q + STAB_ONE;
      // commit on the edge where the count reaches STABLE_CYC
      if (stab_cnt_q == STAB_LAST) begin
        commit  = 1'b1;
        state_d = HOLD;
      end
    end else if ((state_q == HOLD) && samp_match) begin
      state_d = HOLD;
    end else begin
      // IDLE, or SETTLE/HOLD with a changed sample: classify afresh
      if (an_one) begin
        cap_idx_d  = an_idx;
        cap_seg_d  = s_seg_q;
`ifdef SEGDEC_DP_EN
        cap_dp_d   = s_dp_q;
`endif
        stab_cnt_d = STAB_ONE;
        state_d    = SETTLE;
      end else begin
        multi_err = an_multi;
        state_d   = IDLE;
      end
    end
  end

  seg7_pattern_decode u_dec (
    .pat_i      (cap_seg_q),
    .val_o      (dec_val),
    .is_blank_o (dec_blank),
    .is_bad_o   (dec_bad)
  );

  assign exp_idx = (last_idx_q == LAST_IDX) ? '0 : (last_idx_q + IDX_ONE);

  always_comb begin
    digits_d     = digits_q;
    vld_d        = vld_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    stale_d      = stale_q;
    last_idx_d   = last_idx_q;
    tmo_cnt_d    = tmo_cnt_q;
`ifdef SEGDEC_DP_EN
    dp_vals_d    = dp_vals_q;
`endif

    if (multi_err) begin
      err_d      = 1'b1;
      err_code_d = ERR_MULTI_AN;
    end

    if (commit) begin
      last_idx_d   = cap_idx_q;
      tmo_cnt_d    = '0;
      stale_d      = 1'b0;
      frame_done_d = (cap_idx_q == '0) && (last_idx_q == LAST_IDX);
      if (cap_idx_q != exp_idx) begin
        err_d      = 1'b1;
        err_code_d = ERR_ORDER;
      end
      // BAD_SEG overrides ORDER when both hit on one commit
      if (dec_bad) begin
        err_d      = 1'b1;
        err_code_d = ERR_BAD_SEG;
      end else begin
        for (int i = 0; i < NUM_DIG; i++) begin
          if (IDX_W'(i) == cap_idx_q) begin
            if (dec_blank) begin
              vld_d[i] = 1'b0;
            end else begin
              vld_d[i]           = 1'b1;
              digits_d[4*i +: 4] = dec_val;
            end
`ifdef SEGDEC_DP_EN
            dp_vals_d[i] = ~cap_dp_q;
`endif
          end
        end
      end
    end else begin
      if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TMO_ONE;
      if (tmo_cnt_d == TMO_MAX) begin
        stale_d = 1'b1;
        vld_d   = '0;
      end
    end
  end

  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      last_idx_q   <= LAST_IDX;
      tmo_cnt_q    <= '0;
      digits_q     <= '0;
      vld_q        <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      stale_q      <= 1'b0;
`ifdef SEGDEC_DP_EN
      dp_vals_q    <= '0;
`endif
    end else begin
      last_idx_q   <= last_idx_d;
      tmo_cnt_q    <= tmo_cnt_d;
      digits_q     <= digits_d;
      vld_q        <= vld_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      stale_q      <= stale_d;
`ifdef SEGDEC_DP_EN
      dp_vals_q    <= dp_vals_d;
`endif
    end
  end

  assign digits     = digits_q;
  assign digit_vld  = vld_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign stale      = stale_q;
`ifdef SEGDEC_DP_EN
  assign dp_vals    = dp_vals_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  localparam int STAB = 4;
  localparam int TMO  = 64;

  logic        mclk;
  logic        clr_n;
  logic [7:0]  an;
  logic [6:0]  a_to_g;
  logic        dp;
  logic [31:0] digits;
  logic [7:0]  digit_vld;
  logic        frame_done;
  logic        err;
  logic [1:0]  err_code;
  logic        stale;
`ifdef SEGDEC_DP_EN
  logic [7:0]  dp_vals;
`endif

  seg_scan_decoder #(.NUM_DIG(8), .STABLE_CYC(STAB), .TIMEOUT_CYC(TMO)) dut (
    .mclk       (mclk),
    .clr_n      (clr_n),
    .an         (an),
    .a_to_g     (a_to_g),
    .dp         (dp),
    .digits     (digits),
    .digit_vld  (digit_vld),
    .frame_done (frame_done),
    .err        (err),
    .err_code   (err_code),
    .stale      (stale)
`ifdef SEGDEC_DP_EN
    ,
    .dp_vals    (dp_vals)
`endif
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  vld;
    logic        err;
    logic [1:0]  code;
    logic        fd;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] m_digits;
  logic [7:0]  m_vld;
  logic [2:0]  m_last;
  logic [1:0]  m_code;

  logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic model_reset();
    m_digits = '0;
    m_vld    = '0;
    m_last   = 3'd7;
    m_code   = 2'b00;
  endtask

  task automatic do_reset();
    clr_n  = 1'b0;
    an     = 8'hFF;
    a_to_g = 7'h7F;
    dp     = 1'b1;
    tick();
    tick();
    clr_n = 1'b1;
    model_reset();
  endtask

  task automatic model_commit(input logic [2:0] idx, input logic [6:0] seg, output exp_t e);
    logic found, blank, bad, ord;
    logic [3:0] val;
    logic [2:0] expi;
    found = 1'b0;
    val   = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (tbl[k] == seg) begin
        found = 1'b1;
        val   = 4'(k);
      end
    end
    blank = (seg == 7'h7F);
    bad   = !found && !blank;
    expi  = m_last + 3'd1;
    ord   = (idx != expi);
    e.fd  = (idx == 3'd0) && (m_last == 3'd7);
    e.err = bad || ord;
    if (bad) m_code = 2'b01;
    else if (ord) m_code = 2'b11;
    if (!bad) begin
      if (blank) m_vld[idx] = 1'b0;
      else begin
        m_vld[idx] = 1'b1;
        m_digits[4*idx +: 4] = val;
      end
    end
    m_last   = idx;
    e.digits = m_digits;
    e.vld    = m_vld;
    e.code   = m_code;
  endtask

  // Drive one digit dwell; expect no commit after STAB edges, commit on the next.
  task automatic dwell(input logic [2:0] idx, input logic [6:0] seg);
    exp_t e;
    logic [31:0] pre_d;
    logic [7:0]  pre_v;
    pre_d  = m_digits;
    pre_v  = m_vld;
    an     = ~(8'b1 << idx);
    a_to_g = seg;
    model_commit(idx, seg, e);
    sb.push_back(e);
    repeat (STAB) tick();
    n_vec++;
    if (digits !== pre_d || digit_vld !== pre_v || err !== 1'b0) begin
      n_bad++;
      $display("FAIL early_commit idx=%0d got d=%h v=%h e=%b want d=%h v=%h e=0",
               idx, digits, digit_vld, err, pre_d, pre_v);
    end
    tick();
    e = sb.pop_front();
    n_vec++;
    if (digits !== e.digits) begin
      n_bad++; $display("FAIL digits idx=%0d got=%h want=%h", idx, digits, e.digits);
    end
    n_vec++;
    if (digit_vld !== e.vld) begin
      n_bad++; $display("FAIL digit_vld idx=%0d got=%h want=%h", idx, digit_vld, e.vld);
    end
    n_vec++;
    if (err !== e.err) begin
      n_bad++; $display("FAIL err idx=%0d got=%b want=%b", idx, err, e.err);
    end
    n_vec++;
    if (err_code !== e.code) begin
      n_bad++; $display("FAIL err_code idx=%0d got=%b want=%b", idx, err_code, e.code);
    end
    n_vec++;
    if (frame_done !== e.fd) begin
      n_bad++; $display("FAIL frame_done idx=%0d got=%b want=%b", idx, frame_done, e.fd);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({digits, digit_vld, frame_done, err, err_code, stale} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got d=%h v=%h fd=%b e=%b c=%b s=%b",
               digits, digit_vld, frame_done, err, err_code, stale);
    end
    dwell(3'd0, 7'b0100100);
    a_to_g = 7'b0000110;
    tick();
    tick();
    clr_n = 1'b0;
    #1;
    n_vec++;
    if ({digits, digit_vld, frame_done, err, err_code, stale} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got d=%h v=%h fd=%b e=%b c=%b s=%b",
               digits, digit_vld, frame_done, err, err_code, stale);
    end
    model_reset();
    tick();
    tick();
    clr_n = 1'b1;
    dwell(3'd0, 7'b0000110);
  endtask

  task automatic test_long_hold();
    int n_err, n_fd;
    do_reset();
    dwell(3'd0, 7'b0010010);
    n_err = 0;
    n_fd  = 0;
    for (int t = STAB + 2; t <= 100; t++) begin
      tick();
      if (err) n_err++;
      if (frame_done) n_fd++;
      if (t == STAB + 1 + TMO - 1) begin
        n_vec++;
        if (stale !== 1'b0) begin
          n_bad++; $display("FAIL stale_early got=%b want=0", stale);
        end
      end
      if (t == STAB + 1 + TMO) begin
        n_vec++;
        if (stale !== 1'b1 || digit_vld !== 8'h00) begin
          n_bad++; $display("FAIL stale_set got s=%b v=%h want s=1 v=00", stale, digit_vld);
        end
      end
    end
    m_vld = '0;
    n_vec++;
    if (n_err != 0 || n_fd != 0 || stale !== 1'b1 || digits[3:0] !== 4'h2) begin
      n_bad++;
      $display("FAIL single_commit got errs=%0d fds=%0d s=%b d0=%h want 0 0 1 2",
               n_err, n_fd, stale, digits[3:0]);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    an     = 8'hFE;
    a_to_g = 7'b0010010;
    tick();
    tick();
    dwell(3'd0, 7'b0000110);
  endtask

  task automatic test_multi_an();
    exp_t e;
    int n_err;
    e.digits = m_digits;
    e.vld    = m_vld;
    e.err    = 1'b1;
    e.code   = 2'b10;
    e.fd     = 1'b0;
    m_code   = 2'b10;
    sb.push_back(e);
    an = 8'hFC;
    n_err = 0;
    tick();
    if (err) n_err++;
    an = 8'hFF;
    repeat (6) begin
      tick();
      if (err) n_err++;
    end
    e = sb.pop_front();
    n_vec++;
    if (n_err != 1) begin
      n_bad++; $display("FAIL multi_an_pulses got=%0d want=1", n_err);
    end
    n_vec++;
    if (err_code !== e.code) begin
      n_bad++; $display("FAIL multi_an_code got=%b want=%b", err_code, e.code);
    end
    n_vec++;
    if (digits !== e.digits || digit_vld !== e.vld) begin
      n_bad++; $display("FAIL multi_an_digits got d=%h v=%h want d=%h v=%h",
                        digits, digit_vld, e.digits, e.vld);
    end
  endtask

  task automatic test_scan();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dwell(3'(i), tbl[i]);
      tick();
    end
    dwell(3'd0, tbl[8]);
    tick();
    n_vec++;
    if (frame_done !== 1'b0) begin
      n_bad++; $display("FAIL frame_done_width got=%b want=0", frame_done);
    end
    dwell(3'd1, tbl[9]);
    dwell(3'd2, tbl[10]);
    dwell(3'd4, tbl[12]);
  endtask

  task automatic test_bad_seg_stale();
    dwell(3'd5, 7'b1111110);
    dwell(3'd7, 7'b1111110);
    dwell(3'd0, 7'h7F);
    an = 8'hFF;
    repeat (TMO - 1) tick();
    n_vec++;
    if (stale !== 1'b0) begin
      n_bad++; $display("FAIL idle_stale_early got=%b want=0", stale);
    end
    tick();
    n_vec++;
    if (stale !== 1'b1 || digit_vld !== 8'h00) begin
      n_bad++; $display("FAIL idle_stale got s=%b v=%h want s=1 v=00", stale, digit_vld);
    end
    m_vld = '0;
    dwell(3'd1, tbl[0]);
    n_vec++;
    if (stale !== 1'b0) begin
      n_bad++; $display("FAIL stale_clear got=%b want=0", stale);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n  = 1'b0;
    an     = 8'hFF;
    a_to_g = 7'h7F;
    dp     = 1'b1;
    model_reset();
    test_reset();
    test_long_hold();
    test_glitch();
    test_multi_an();
    test_scan();
    test_bad_seg_stale();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
